midi_byte_writer: RTL and testbench
===================================

// Module: midi_byte_writer
// PURPOSE
//  MIDI serial transmitter: queues bytes from synth/sequencer logic and emits each on MIDI_TX
//  as a 31,250 baud frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//  Small FIFO decouples producers from the 320 us frame time. Sits next to the MIDI byte receiver (MIDI THRU/OUT path).
// PARAMETERS
//  TICKS_PER_BIT  1600  CLOCK_50 cycles per MIDI bit (50,000,000 / 31,250)
//  FIFO_DEPTH     4     queued bytes; power of two, 2..16
// PORTS
//  CLOCK_50         input   1  system clock, 50 MHz
//  RESET            input   1  synchronous, active-high reset
//  sendByte         input   1  producer valid; byte accepted on a rising edge when sendByte && isReady
//  byteValue        input   8  byte to transmit, sampled with sendByte
//  isReady          output  1  FIFO not full (combinational from occupancy)
//  isBusy           output  1  frame in progress or FIFO non-empty
//  MIDI_TX          output  1  serial line, idle high, registered
// BEHAVIOUR
//  - Reset values: MIDI_TX=1, isBusy=0, isReady=1; FIFO empty, state IDLE, counters 0.
//  - RESET mid-frame: frame aborted, MIDI_TX=1 from the next cycle, queued bytes discarded.
//  - FIFO: write ptr, read ptr, occupancy counter. Occupancy 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
//    Push when sendByte && isReady. Push while full is ignored (byte dropped, no state change).
//    Push and pop in the same cycle: occupancy unchanged, both pointers advance.
//  - States: IDLE -> START -> DATA -> STOP -> IDLE.
//    IDLE: MIDI_TX=1. If FIFO non-empty: pop into shift reg, bitCount=0, tickCount=0, go START.
//    START: MIDI_TX=0 for TICKS_PER_BIT cycles, then go DATA.
//    DATA: MIDI_TX=shift[0] for TICKS_PER_BIT cycles per bit. Shift right after each bit. After bit 7, go STOP.
//    STOP: MIDI_TX=1 for TICKS_PER_BIT cycles, then go IDLE.
//  - tickCount counts 0..TICKS_PER_BIT-1, width $clog2(TICKS_PER_BIT). Terminal count advances the bit.
//  - Latency: with machine IDLE and FIFO empty, a byte accepted at edge N drives MIDI_TX low
//    from edge N+2, for exactly TICKS_PER_BIT cycles.
//  - Frame = 10*TICKS_PER_BIT = 16,000 cycles. Back-to-back queued bytes add exactly 1 idle cycle
//    (the IDLE pop cycle) between the stop bit and the next start bit.
//  - isBusy = (state != IDLE) || occupancy != 0. Falls in the cycle after the last STOP completes.
// CONFIGURATION
//  MIDI_RUNNING_STATUS_EN defined: running-status compression on the pop path.
//    - Register runStatus, valid flag; reset clears valid.
//    - Popped 0x80-0xEF equal to a valid runStatus: discarded, no frame, stays IDLE.
//      Any other 0x80-0xEF: transmitted, becomes runStatus.
//    - 0xF0-0xF7: transmitted, runStatus invalidated.
//    - 0xF8-0xFF (realtime) and data bytes 0x00-0x7F: transmitted, runStatus unchanged.
//    - A discarded pop takes one IDLE cycle; the next byte may pop on the following cycle.
//  MIDI_RUNNING_STATUS_EN undefined: every accepted byte is transmitted verbatim; no runStatus logic.
// TESTING
//  Bench uses TICKS_PER_BIT=16 for speed, except scenario 1.
//  1 Default params, push 0x90 while idle -> MIDI_TX low at N+2 for 1600 cycles.
//    Then bits 0,0,0,0,1,0,0,1 at 1600 cycles each, stop high 1600 cycles, isBusy low after.
//  2 Push 0x3C,0x64,0x00,0x7F,0x55 on consecutive cycles (depth 4, idle) ->
//    isReady stays 1: first pop frees a slot before the 5th push. All five frames sent in order, 1 idle cycle between frames.
//  3 Hold sendByte with 0xAA while full -> extra pushes ignored.
//    Exactly FIFO_DEPTH+1 frames observed (in-flight frame + full FIFO).
//  4 Assert RESET at start bit tick 8 of byte 2 with 2 bytes queued ->
//    MIDI_TX=1 next cycle, isBusy=0, isReady=1; no further frames.
//  5 MIDI_RUNNING_STATUS_EN, push 0x90,0x3C,0x64,0x90,0x3E,0x64 -> frames 0x90,0x3C,0x64,0x3E,0x64.
//  6 MIDI_RUNNING_STATUS_EN, push 0x90,0xF8,0x90,0xF0,0x90 -> frames 0x90,0xF8,0xF0,0x90.
//    Scenario 5 without the macro -> all six bytes framed.

Source files
------------

// File: rtl/midi_byte_writer.sv
// midi_byte_writer: MIDI OUT serial transmitter.
// Queues bytes in a small FIFO and sends each as a 31,250 baud frame on MIDI_TX:
// one start bit (0), eight data bits LSB first, one stop bit (1).
// Optional build macro MIDI_RUNNING_STATUS_EN: drops channel-status bytes that repeat
// the current running status on the pop path instead of framing them.
module midi_byte_writer #(
    parameter int unsigned TICKS_PER_BIT = 1600,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       sendByte,
    input  logic [7:0] byteValue,
    output logic       isReady,
    output logic       isBusy,
    output logic       MIDI_TX
);

    localparam int unsigned TICK_W = $clog2(TICKS_PER_BIT);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} txStateT;

    txStateT           stateQ, stateD;
    logic [TICK_W-1:0] tickQ, tickD;
    logic [2:0]        bitQ, bitD;
    logic [7:0]        shiftQ, shiftD;
    logic              txQ, txD;

    logic [7:0]        fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtrQ, rdPtrQ;
    logic [OCC_W-1:0]  occQ;

    logic              push, pop, discard, tickDone;
    logic [7:0]        headByte;

    assign headByte = fifoMem[rdPtrQ];
    assign isReady  = (occQ != OCC_FULL);
    assign isBusy   = (stateQ != StIdle) || (occQ != '0);
    assign push     = sendByte && isReady;
    assign tickDone = (tickQ == TICK_LAST);
    assign MIDI_TX  = txQ;

`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] runStatusQ, runStatusD;
    logic       rsValidQ, rsValidD;
    logic       isChannel, isSysCommon;

    assign isChannel   = headByte[7] && (headByte[7:4] != 4'hF);
    assign isSysCommon = (headByte[7:3] == 5'b11110);
    // A repeated channel status is popped but never framed
    assign discard     = isChannel && rsValidQ && (headByte == runStatusQ);

    // Running-status tracking on every byte that actually gets framed
    always_comb begin
        runStatusD = runStatusQ;
        rsValidD   = rsValidQ;
        if (pop && !discard) begin
            if (isChannel) begin
                runStatusD = headByte;
                rsValidD   = 1'b1;
            end else if (isSysCommon) begin
                rsValidD   = 1'b0;
            end
        end
    end

    // Running-status register
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            runStatusQ <= 8'h00;
            rsValidQ   <= 1'b0;
        end else begin
            runStatusQ <= runStatusD;
            rsValidQ   <= rsValidD;
        end
    end
`else
    assign discard = 1'b0;
`endif

    // Frame sequencer: next state, bit timing and next serial level
    always_comb begin
        stateD = stateQ;
        tickD  = tickQ;
        bitD   = bitQ;
        shiftD = shiftQ;
        txD    = 1'b1;
        pop    = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (occQ != '0) begin
                    pop = 1'b1;
                    if (!discard) begin
                        shiftD = headByte;
                        tickD  = '0;
                        bitD   = '0;
                        stateD = StStart;
                    end
                end
            end
            StStart: begin
                txD = 1'b0;
                if (tickDone) begin
                    tickD  = '0;
                    stateD = StData;
                end else begin
                    tickD = tickQ + TICK_W'(1);
                end
            end
            StData: begin
                txD = shiftQ[0];
                if (tickDone) begin
                    tickD  = '0;
                    shiftD = shiftQ >> 1;
                    if (bitQ == 3'd7) begin
                        stateD = StStop;
                    end else begin
                        bitD = bitQ + 3'd1;
                    end
                end else begin
                    tickD = tickQ + TICK_W'(1);
                end
            end
            StStop: begin
                if (tickDone) begin
                    tickD  = '0;
                    stateD = StIdle;
                end else begin
                    tickD = tickQ + TICK_W'(1);
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Sequencer state and registered serial output (lags the state by one cycle)
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            stateQ <= StIdle;
            tickQ  <= '0;
            bitQ   <= '0;
            shiftQ <= 8'h00;
            txQ    <= 1'b1;
        end else begin
            stateQ <= stateD;
            tickQ  <= tickD;
            bitQ   <= bitD;
            shiftQ <= shiftD;
            txQ    <= txD;
        end
    end

    // FIFO storage; contents need no reset since occupancy guards reads
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifoMem[wrPtrQ] <= byteValue;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wrPtrQ <= '0;
            rdPtrQ <= '0;
            occQ   <= '0;
        end else begin
            if (push) begin
                wrPtrQ <= wrPtrQ + PTR_W'(1);
            end
            if (pop) begin
                rdPtrQ <= rdPtrQ + PTR_W'(1);
            end
            if (push && !pop) begin
                occQ <= occQ + OCC_W'(1);
            end else if (!push && pop) begin
                occQ <= occQ - OCC_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_midi_byte_writer.sv
// Bench for midi_byte_writer: a slow instance (default timing) for the exact-timing frame
// and a fast instance (16 ticks per bit) whose frames are decoded by a scoreboard monitor.
module tb_midi_byte_writer;

    localparam int unsigned SLOW_T = 1600;
    localparam int unsigned FAST_T = 16;
    localparam int unsigned DEPTH  = 4;
    localparam int          G      = 10 * FAST_T + 1;   // start-to-start of back-to-back frames

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    int cycle = 0;
    always @(posedge CLOCK_50) cycle <= cycle + 1;

    int testsRun = 0;
    int testsFailed = 0;

    logic       rstS = 1'b1, sendS = 1'b0;
    logic [7:0] byteS = 8'h00;
    logic       readyS, busyS, txS;
    logic       rstF = 1'b1, sendF = 1'b0;
    logic [7:0] byteF = 8'h00;
    logic       readyF, busyF, txF;

    midi_byte_writer #(.TICKS_PER_BIT(SLOW_T), .FIFO_DEPTH(DEPTH)) dutSlow (
        .CLOCK_50 (CLOCK_50),
        .RESET    (rstS),
        .sendByte (sendS),
        .byteValue(byteS),
        .isReady  (readyS),
        .isBusy   (busyS),
        .MIDI_TX  (txS)
    );

    midi_byte_writer #(.TICKS_PER_BIT(FAST_T), .FIFO_DEPTH(DEPTH)) dutFast (
        .CLOCK_50 (CLOCK_50),
        .RESET    (rstF),
        .sendByte (sendF),
        .byteValue(byteF),
        .isReady  (readyF),
        .isBusy   (busyF),
        .MIDI_TX  (txF)
    );

    // Scoreboard: expected byte and expected start-to-start distance (0 = not checked)
    logic [7:0] expByte[$];
    int         expGap[$];

    task automatic check(input string name, input int actual, input int required);
        testsRun++;
        if (actual != required) begin
            testsFailed++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)",
                     name, actual, actual, required, required);
        end
    endtask

    task automatic skipCycles(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            if (rstF) ab = 1'b1;
        end
    endtask

    // Monitor: decodes fast-instance frames mid-bit and compares against the scoreboard
    initial begin : monitor
        int         s;
        int         lastStart;
        int         g;
        bit         aborted;
        logic [7:0] got;
        logic [7:0] want;
        logic       startBit, stopBit;
        lastStart = -1;
        forever begin
            @(negedge CLOCK_50);
            if (!rstF && txF === 1'b0) begin
                s = cycle;
                aborted = 1'b0;
                skipCycles(FAST_T / 2, aborted);
                startBit = txF;
                for (int k = 0; k < 8; k++) begin
                    skipCycles(FAST_T, aborted);
                    got[k] = txF;
                end
                skipCycles(FAST_T, aborted);
                stopBit = txF;
                skipCycles(FAST_T / 2, aborted);
                if (aborted) begin
                    lastStart = -1;
                end else begin
                    check("frame has scoreboard entry", int'(expByte.size() > 0), 1);
                    if (expByte.size() > 0) begin
                        want = expByte.pop_front();
                        g = expGap.pop_front();
                        check($sformatf("frame byte @%0d", s), int'(got), int'(want));
                        check($sformatf("frame start/stop bits @%0d", s),
                              int'({startBit, stopBit}), 1);
                        if (g != 0 && lastStart >= 0) begin
                            check($sformatf("frame spacing @%0d", s), s - lastStart, g);
                        end
                    end
                    lastStart = s;
                end
            end
        end
    end

    // gap < 0: byte is pushed but no frame is expected for it
    task automatic pushFast(input logic [7:0] b, input int gap, input bit mustBeReady);
        int guard;
        guard = 0;
        @(negedge CLOCK_50);
        if (mustBeReady) check($sformatf("isReady at push 0x%0h", b), int'(readyF), 1);
        while (!readyF && guard < 2000) begin
            sendF = 1'b0;
            guard++;
            @(negedge CLOCK_50);
        end
        if (!readyF) check("isReady wait bound", int'(readyF), 1);
        sendF = 1'b1;
        byteF = b;
        if (gap >= 0) begin
            expByte.push_back(b);
            expGap.push_back(gap);
        end
        @(posedge CLOCK_50);
    endtask

    task automatic releaseFast();
        @(negedge CLOCK_50);
        sendF = 1'b0;
    endtask

    task automatic waitIdleFast(input string name);
        int guard;
        guard = 0;
        @(negedge CLOCK_50);
        while (busyF && guard < 5000) begin
            guard++;
            @(negedge CLOCK_50);
        end
        check({name, " isBusy drops"}, int'(busyF), 0);
        repeat (2 * FAST_T) @(negedge CLOCK_50);
    endtask

    initial begin : stimulus
        logic [7:0] b;
        logic       lv [10];
        int         errs;
        int         lows;

        // Reset values
        repeat (3) @(negedge CLOCK_50);
        check("reset slow MIDI_TX", int'(txS), 1);
        check("reset slow isBusy", int'(busyS), 0);
        check("reset slow isReady", int'(readyS), 1);
        check("reset fast MIDI_TX", int'(txF), 1);
        check("reset fast isBusy", int'(busyF), 0);
        check("reset fast isReady", int'(readyF), 1);
        rstS = 1'b0;
        rstF = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        // 1: default timing, 0x90 from idle
        b = 8'h90;
        lv[0] = 1'b0;
        for (int k = 0; k < 8; k++) lv[k + 1] = b[k];
        lv[9] = 1'b1;
        sendS = 1'b1;
        byteS = b;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        sendS = 1'b0;
        check("s1 MIDI_TX after accept edge", int'(txS), 1);
        @(negedge CLOCK_50);
        check("s1 MIDI_TX one edge later", int'(txS), 1);
        check("s1 isBusy while queued", int'(busyS), 1);
        for (int k = 0; k < 10; k++) begin
            errs = 0;
            for (int t = 0; t < int'(SLOW_T); t++) begin
                @(negedge CLOCK_50);
                if (txS !== lv[k]) errs++;
            end
            check($sformatf("s1 bit %0d wrong-level cycles", k), errs, 0);
        end
        check("s1 isBusy after stop", int'(busyS), 0);
        @(negedge CLOCK_50);
        check("s1 MIDI_TX idle after frame", int'(txS), 1);

        // 2: five consecutive pushes into depth 4
        pushFast(8'h3C, 0, 1'b1);
        pushFast(8'h64, G, 1'b1);
        pushFast(8'h00, G, 1'b1);
        pushFast(8'h7F, G, 1'b1);
        pushFast(8'h55, G, 1'b1);
        releaseFast();
        waitIdleFast("s2");

        // 3: hold sendByte while full
        sendF = 1'b1;
        byteF = 8'hAA;
        for (int i = 0; i <= int'(DEPTH); i++) begin
            expByte.push_back(8'hAA);
            expGap.push_back(i == 0 ? 0 : G);
        end
        repeat (12) @(negedge CLOCK_50);
        check("s3 isReady while full", int'(readyF), 0);
        sendF = 1'b0;
        waitIdleFast("s3");

        // 4: reset during start bit of byte 2 with two bytes queued
        pushFast(8'h11, 0, 1'b1);
        pushFast(8'h22, -1, 1'b1);
        pushFast(8'h33, -1, 1'b1);
        pushFast(8'h44, -1, 1'b1);
        releaseFast();
        repeat (7 + 10 * FAST_T) @(negedge CLOCK_50);
        check("s4 second start bit low", int'(txF), 0);
        check("s4 isBusy before reset", int'(busyF), 1);
        rstF = 1'b1;
        @(negedge CLOCK_50);
        check("s4 MIDI_TX after reset", int'(txF), 1);
        check("s4 isBusy after reset", int'(busyF), 0);
        check("s4 isReady after reset", int'(readyF), 1);
        repeat (2) @(negedge CLOCK_50);
        rstF = 1'b0;
        lows = 0;
        for (int i = 0; i < 3 * G; i++) begin
            @(negedge CLOCK_50);
            if (txF !== 1'b1) lows++;
        end
        check("s4 line quiet after reset", lows, 0);
        check("s4 isBusy stays low", int'(busyF), 0);

        // 5: note-on pair with repeated status
`ifdef MIDI_RUNNING_STATUS_EN
        pushFast(8'h90, 0, 1'b0);
        pushFast(8'h3C, G, 1'b0);
        pushFast(8'h64, G, 1'b0);
        pushFast(8'h90, -1, 1'b0);
        pushFast(8'h3E, G + 1, 1'b0);
        pushFast(8'h64, G, 1'b0);
`else
        pushFast(8'h90, 0, 1'b0);
        pushFast(8'h3C, G, 1'b0);
        pushFast(8'h64, G, 1'b0);
        pushFast(8'h90, G, 1'b0);
        pushFast(8'h3E, G, 1'b0);
        pushFast(8'h64, G, 1'b0);
`endif
        releaseFast();
        waitIdleFast("s5");

        // Clear running status left by scenario 5
        rstF = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        rstF = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        // 6: realtime keeps status, system common clears it
`ifdef MIDI_RUNNING_STATUS_EN
        pushFast(8'h90, 0, 1'b1);
        pushFast(8'hF8, G, 1'b1);
        pushFast(8'h90, -1, 1'b1);
        pushFast(8'hF0, G + 1, 1'b1);
        pushFast(8'h90, G, 1'b1);
`else
        pushFast(8'h90, 0, 1'b1);
        pushFast(8'hF8, G, 1'b1);
        pushFast(8'h90, G, 1'b1);
        pushFast(8'hF0, G, 1'b1);
        pushFast(8'h90, G, 1'b1);
`endif
        releaseFast();
        waitIdleFast("s6");

        check("scoreboard drained", expByte.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
